// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : timer_bank
//  Purpose  : Bank of CHANNELS independent down-counting timers. Each channel
//             has a reload value, a prescaler, periodic/one-shot modes, an
//             external rising-edge tick source, a sticky terminal-count flag
//             and an interrupt output. Configured through a register-write
//             port and observed through a registered read port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          clock
//    reset        asynchronous, active-high reset
//    cfg_we_i     register write strobe
//    cfg_ch_i     channel selected for write (out-of-range writes ignored)
//    cfg_addr_i   0=reload 1=control 2=prescale 3=flag clear (wdata[0])
//    cfg_wdata_i  write data
//    rd_ch_i      channel selected for read (out-of-range reads return 0)
//    rd_addr_i    0=reload 1=control 2=current count 3=status {0,flag}
//    rd_data_o    registered read data (1-cycle latency)
//    ext_tick_i   per-channel external tick, synchronous to clk
//    tc_pulse_o   per-channel one-cycle terminal-count pulse
//    irq_o        per-channel flag & irq_en
//  Control bits: [0] enable, [1] one_shot, [2] src (1=ext), [3] irq_en
// ============================================================================
module timer_bank #(
    parameter  int WIDTH      = 16,
    parameter  int CHANNELS   = 3,
    parameter  int PRESCALE_W = 8,
    localparam int CW         = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we_i,
    input  logic [CW-1:0]       cfg_ch_i,
    input  logic [1:0]          cfg_addr_i,
    input  logic [WIDTH-1:0]    cfg_wdata_i,
    input  logic [CW-1:0]       rd_ch_i,
    input  logic [1:0]          rd_addr_i,
    output logic [WIDTH-1:0]    rd_data_o,
    input  logic [CHANNELS-1:0] ext_tick_i,
    output logic [CHANNELS-1:0] tc_pulse_o,
    output logic [CHANNELS-1:0] irq_o
);

    localparam logic [1:0] ADDR_RELOAD   = 2'd0;
    localparam logic [1:0] ADDR_CONTROL  = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_FLAG     = 2'd3;

    // Flattened per-channel state, gathered for the read mux.
    logic [CHANNELS*WIDTH-1:0] reload_all;
    logic [CHANNELS*WIDTH-1:0] count_all;
    logic [CHANNELS*4-1:0]     ctrl_all;
    logic [CHANNELS-1:0]       flag_all;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0]      count_q, count_d;
        logic [WIDTH-1:0]      reload_q, reload_d;
        logic [3:0]            ctrl_q, ctrl_d;
        logic [PRESCALE_W-1:0] prescale_q, prescale_d;
        logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
        logic                  flag_q, flag_d;
        logic                  tc_q, tc_d;
        logic                  ext_q;
        logic                  wr_sel;
        logic                  pre_run;
        logic                  pre_tick;
        logic                  ext_tick;
        logic                  tick;

        // An out-of-range cfg_ch_i matches no channel, so the write is dropped.
        assign wr_sel   = cfg_we_i && (cfg_ch_i == CW'(g));
        assign pre_run  = ctrl_q[0] & ~ctrl_q[2];
        assign pre_tick = pre_run && (pre_cnt_q == prescale_q);
        assign ext_tick = ctrl_q[0] & ctrl_q[2] & ext_tick_i[g] & ~ext_q;
        assign tick     = pre_tick | ext_tick;

        always_comb begin
            count_d    = count_q;
            reload_d   = reload_q;
            ctrl_d     = ctrl_q;
            prescale_d = prescale_q;
            flag_d     = flag_q;
            tc_d       = 1'b0;
            // Prescaler free-runs while enabled on the internal source and
            // sits at zero otherwise.
            pre_cnt_d  = '0;
            if (pre_run && !pre_tick) begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end

            // Configuration writes (other than flag clear) take priority and
            // swallow any tick landing in the same cycle.
            if (wr_sel && cfg_addr_i == ADDR_RELOAD) begin
                reload_d  = cfg_wdata_i;
                count_d   = cfg_wdata_i;
                pre_cnt_d = '0;
            end else if (wr_sel && cfg_addr_i == ADDR_CONTROL) begin
                ctrl_d = cfg_wdata_i[3:0];
            end else if (wr_sel && cfg_addr_i == ADDR_PRESCALE) begin
                prescale_d = cfg_wdata_i[PRESCALE_W-1:0];
                pre_cnt_d  = '0;
            end else if (tick) begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    tc_d = 1'b1;
                    if (ctrl_q[1]) begin
                        ctrl_d[0] = 1'b0;
                    end else begin
                        count_d = reload_q;
                    end
                end
            end

            // Set wins over a simultaneous clear.
            if (wr_sel && cfg_addr_i == ADDR_FLAG && cfg_wdata_i[0]) begin
                flag_d = 1'b0;
            end
            if (tc_d) begin
                flag_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_q    <= '0;
                reload_q   <= '0;
                ctrl_q     <= '0;
                prescale_q <= '0;
                pre_cnt_q  <= '0;
                flag_q     <= 1'b0;
                tc_q       <= 1'b0;
                ext_q      <= 1'b0;
            end else begin
                count_q    <= count_d;
                reload_q   <= reload_d;
                ctrl_q     <= ctrl_d;
                prescale_q <= prescale_d;
                pre_cnt_q  <= pre_cnt_d;
                flag_q     <= flag_d;
                tc_q       <= tc_d;
                ext_q      <= ext_tick_i[g];
            end
        end

        assign reload_all[g*WIDTH +: WIDTH] = reload_q;
        assign count_all[g*WIDTH +: WIDTH]  = count_q;
        assign ctrl_all[g*4 +: 4]           = ctrl_q;
        assign flag_all[g]                  = flag_q;
        assign tc_pulse_o[g]                = tc_q;
        assign irq_o[g]                     = flag_q & ctrl_q[3];
    end

    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch_i == CW'(i)) begin
                case (rd_addr_i)
                    ADDR_RELOAD:  rd_data_d = reload_all[i*WIDTH +: WIDTH];
                    ADDR_CONTROL: rd_data_d = {{(WIDTH-4){1'b0}}, ctrl_all[i*4 +: 4]};
                    2'd2:         rd_data_d = count_all[i*WIDTH +: WIDTH];
                    default:      rd_data_d = {{(WIDTH-1){1'b0}}, flag_all[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_bank
//  Purpose  : Self-checking bench for timer_bank. Directed scenarios followed
//             by random register traffic, every cycle compared against a
//             behavioural per-channel model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_bank;

    localparam int W   = 16;
    localparam int NCH = 3;
    localparam int PW  = 8;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [1:0]     cfg_addr;
    logic [W-1:0]   cfg_wdata;
    logic [CW-1:0]  rd_ch;
    logic [1:0]     rd_addr;
    logic [W-1:0]   rd_data;
    logic [NCH-1:0] ext_tick;
    logic [NCH-1:0] tc_pulse;
    logic [NCH-1:0] irq;

    timer_bank #(.WIDTH(W), .CHANNELS(NCH), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we_i    (cfg_we),
        .cfg_ch_i    (cfg_ch),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .rd_ch_i     (rd_ch),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .ext_tick_i  (ext_tick),
        .tc_pulse_o  (tc_pulse),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [W-1:0]  m_count  [NCH];
    logic [W-1:0]  m_reload [NCH];
    logic [3:0]    m_ctrl   [NCH];
    logic [PW-1:0] m_pre    [NCH];
    logic [PW-1:0] m_pcnt   [NCH];
    logic          m_flag   [NCH];
    logic          m_ext    [NCH];
    logic          m_tc     [NCH];
    logic [W-1:0]  m_rd;

    int n_vec = 0;
    int n_err = 0;
    int tc_seen [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_count[c] = '0; m_reload[c] = '0; m_ctrl[c] = '0; m_pre[c] = '0;
            m_pcnt[c] = '0;  m_flag[c] = 1'b0; m_ext[c] = 1'b0; m_tc[c] = 1'b0;
        end
        m_rd = '0;
    endtask

    // One clock edge worth of the timer rules, using the inputs present at it.
    task automatic model_step();
        logic en, src, prun, ptick, etick, tick, wr, tc;
        if (reset) begin
            model_reset();
            return;
        end
        m_rd = '0;
        if (int'(rd_ch) < NCH) begin
            case (rd_addr)
                2'd0:    m_rd = m_reload[rd_ch];
                2'd1:    m_rd = {12'b0, m_ctrl[rd_ch]};
                2'd2:    m_rd = m_count[rd_ch];
                default: m_rd = {15'b0, m_flag[rd_ch]};
            endcase
        end
        for (int c = 0; c < NCH; c++) begin
            en    = m_ctrl[c][0];
            src   = m_ctrl[c][2];
            prun  = en && !src;
            ptick = prun && (m_pcnt[c] == m_pre[c]);
            etick = en && src && ext_tick[c] && !m_ext[c];
            tick  = ptick || etick;
            wr    = cfg_we && (int'(cfg_ch) == c);
            tc    = 1'b0;
            m_ext[c]  = ext_tick[c];
            m_pcnt[c] = prun ? (ptick ? 8'd0 : 8'(m_pcnt[c] + 8'd1)) : 8'd0;
            if (wr && cfg_addr == 2'd0) begin
                m_reload[c] = cfg_wdata;
                m_count[c]  = cfg_wdata;
                m_pcnt[c]   = '0;
            end else if (wr && cfg_addr == 2'd1) begin
                m_ctrl[c] = cfg_wdata[3:0];
            end else if (wr && cfg_addr == 2'd2) begin
                m_pre[c]  = cfg_wdata[PW-1:0];
                m_pcnt[c] = '0;
            end else if (tick) begin
                if (m_count[c] != 0) begin
                    m_count[c] = m_count[c] - 16'd1;
                end else begin
                    tc = 1'b1;
                    if (m_ctrl[c][1]) m_ctrl[c][0] = 1'b0;
                    else              m_count[c]   = m_reload[c];
                end
            end
            if (wr && cfg_addr == 2'd3 && cfg_wdata[0]) m_flag[c] = 1'b0;
            if (tc) m_flag[c] = 1'b1;
            m_tc[c] = tc;
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0] e_tc, e_irq;
        for (int c = 0; c < NCH; c++) begin
            e_tc[c]  = m_tc[c];
            e_irq[c] = m_flag[c] & m_ctrl[c][3];
        end
        check("tc_pulse", 32'(tc_pulse), 32'(e_tc));
        check("irq",      32'(irq),      32'(e_irq));
        check("rd_data",  32'(rd_data),  32'(m_rd));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        for (int c = 0; c < NCH; c++) tc_seen[c] += int'(tc_pulse[c]);
    endtask

    task automatic clr_seen();
        for (int c = 0; c < NCH; c++) tc_seen[c] = 0;
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_addr  = 2'(addr);
        cfg_wdata = W'(data);
        cycle();
        cfg_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        rd_ch = '0; rd_addr = '0; ext_tick = '0;
        model_reset();
        clr_seen();
        @(posedge clk); @(posedge clk); #1;
        compare_all();
        #2 reset = 1'b0;

        // Periodic, prescale 0, reload 3, irq enabled on ch0
        rd_ch = 2'd0; rd_addr = 2'd2;
        wr(0, 0, 3);
        wr(0, 1, 9);
        clr_seen();
        repeat (12) cycle();
        check("p0_tc_count", 32'(tc_seen[0]), 32'd3);
        check("p0_irq_set",  32'(irq[0]), 32'd1);
        wr(0, 3, 1);
        check("p0_irq_clr",  32'(irq[0]), 32'd0);
        wr(0, 1, 0);

        // Prescaled one-shot on ch1: single tc 15 cycles after enable
        wr(1, 2, 4);
        wr(1, 0, 2);
        wr(1, 1, 3);
        clr_seen();
        repeat (14) cycle();
        check("os_no_early_tc", 32'(tc_seen[1]), 32'd0);
        cycle();
        check("os_tc_at_15", 32'(tc_pulse[1]), 32'd1);
        repeat (15) cycle();
        check("os_single_tc", 32'(tc_seen[1]), 32'd1);
        rd_ch = 2'd1; rd_addr = 2'd1;
        cycle();
        check("os_ctrl_rb", 32'(rd_data), 32'h2);

        // External source on ch1: held level then three pulses => 4 ticks
        wr(1, 0, 1);
        wr(1, 1, 5);
        clr_seen();
        ext_tick = 3'b010;
        repeat (5) cycle();
        ext_tick = 3'b000;
        cycle();
        for (int k = 0; k < 3; k++) begin
            ext_tick = 3'b010; cycle();
            ext_tick = 3'b000; cycle();
        end
        check("ext_tc_count", 32'(tc_seen[1]), 32'd2);
        wr(1, 1, 0);

        // Collisions on ch2
        wr(2, 0, 1);
        wr(2, 1, 1);
        cycle();
        wr(2, 0, 5);
        check("col_reload_no_tc", 32'(tc_pulse[2]), 32'd0);
        rd_ch = 2'd2; rd_addr = 2'd2;
        cycle();
        check("col_count_new", 32'(rd_data), 32'd5);
        repeat (4) cycle();
        wr(2, 3, 1);
        check("col_clr_tc", 32'(tc_pulse[2]), 32'd1);
        rd_addr = 2'd3;
        cycle();
        check("col_flag_kept", 32'(rd_data), 32'd1);

        // Independence: periods 3, 4, 5 over 60 cycles, sweeping every read
        wr(0, 0, 2); wr(0, 1, 9);
        wr(1, 2, 0); wr(1, 0, 3); wr(1, 1, 1);
        wr(2, 0, 4); wr(2, 1, 1);
        clr_seen();
        for (int i = 0; i < 60; i++) begin
            rd_ch   = CW'(i % 4);
            rd_addr = 2'((i / 4) % 4);
            cycle();
        end
        check("ind_tc0", 32'(tc_seen[0]), 32'd20);
        check("ind_tc1", 32'(tc_seen[1]), 32'd15);
        check("ind_tc2", 32'(tc_seen[2]), 32'd12);
        rd_ch = 2'd3; rd_addr = 2'd2;
        cycle();
        check("rd_bad_ch", 32'(rd_data), 32'd0);

        // Asynchronous reset between edges while counting
        rd_ch = 2'd0; rd_addr = 2'd0;
        cycle();
        #3 reset = 1'b1;
        #1;
        check("rst_tc",  32'(tc_pulse), 32'd0);
        check("rst_irq", 32'(irq),      32'd0);
        check("rst_rd",  32'(rd_data),  32'd0);
        model_reset();
        repeat (3) cycle();
        #3 reset = 1'b0;
        clr_seen();
        rd_addr = 2'd2;
        repeat (20) cycle();
        check("post_rst_quiet", 32'(tc_seen[0] + tc_seen[1] + tc_seen[2]), 32'd0);

        // Random register traffic
        for (int i = 0; i < 2500; i++) begin
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_ch   = CW'($urandom_range(0, 3));
            cfg_addr = 2'($urandom_range(0, 3));
            if (cfg_addr == 2'd1 || cfg_addr == 2'd3 || $urandom_range(0, 7) == 0)
                cfg_wdata = W'($urandom);
            else
                cfg_wdata = W'($urandom_range(0, 5));
            ext_tick = NCH'($urandom);
            rd_ch    = CW'($urandom_range(0, 3));
            rd_addr  = 2'($urandom_range(0, 3));
            cycle();
        end
        cfg_we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_bank.md
# timer_bank

Bank of CHANNELS independent programmable down-counting timers. Each channel has a reload value, an 8-bit-class prescaler, periodic/one-shot modes, an external tick source, a sticky terminal-count flag and an interrupt output. It is the parametrised successor to the library's single counters and fixed clock divider. System/GPU logic uses it for frame timing, periodic events and root-counter style interrupts through a simple register-write/registered-read port.

## Interface
- WIDTH, 16, width of the counter, reload and cfg/rd data paths
- CHANNELS, 3, number of timer channels (>= 2)
- PRESCALE_W, 8, prescaler width (<= WIDTH)
- CW (localparam), $clog2(CHANNELS), channel-select width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  register write strobe
- cfg_ch  in  CW  channel selected for write
- cfg_addr  in  2  0=reload, 1=control, 2=prescale, 3=flag clear
- cfg_wdata  in  WIDTH  write data
- rd_ch  in  CW  channel selected for read
- rd_addr  in  2  0=reload, 1=control, 2=current count, 3=status
- rd_data  out  WIDTH  registered read data
- ext_tick  in  CHANNELS  per-channel external tick, synchronous to clk
- tc_pulse  out  CHANNELS  one-cycle terminal-count pulse
- irq  out  CHANNELS  flag & irq_en, per channel

## Operation
- Control bits: [0] enable, [1] one_shot, [2] src (0 = prescaled clk, 1 = ext_tick rising edge), [3] irq_en. All other bits are ignored and read as 0.
- Prescaler: runs only while enable=1 and src=0. pre_cnt increments each cycle. When pre_cnt==prescale, it generates a tick and pre_cnt<=0. prescale=0 gives a tick every cycle. pre_cnt is held at 0 while the prescaler is not running.
- External source: ext_q<=ext_tick each cycle. Tick = ext_tick & ~ext_q & enable & src.
- On a tick with count!=0: count<=count-1.
- On a tick with count==0:
  - tc_pulse<=1 and flag<=1.
  - Periodic mode: count<=reload.
  - One-shot mode: count stays 0 and enable<=0.
- Period is therefore (reload+1) ticks. reload=0 in periodic mode produces tc on every tick.
- Write reload: reload<=wdata, count<=wdata, pre_cnt<=0.
- Write control: updates the control bits only. count is unchanged, so re-enabling resumes from the current count.
- Write prescale: prescale<=wdata[PRESCALE_W-1:0], pre_cnt<=0.
- Write addr 3 with wdata[0]=1: flag<=0. wdata[0]=0 has no effect.
- Status read: {…0, flag}. Control read returns the live enable bit, including a one-shot auto-clear.
- cfg_ch >= CHANNELS: the write is ignored. rd_ch >= CHANNELS: rd_data<=0.
- Simultaneous events, same channel, same cycle:
  - A reload, control or prescale write beats a tick. The tick is dropped and no tc occurs.
  - A flag-clear write with a tc: the flag stays set (set wins) and tc_pulse still fires.
  - Events on different channels are fully independent.
- A tick arriving while enable=0 has no effect.

## Timing
- All state is registered. tc_pulse and rd_data are registers. irq is combinational from registered flag and irq_en.
- Reset (async, any time, including mid-count): count, reload, control, prescale, pre_cnt, flag, ext_q, tc_pulse and rd_data are all cleared to 0. Consequently irq=0.
- Read latency is 1 cycle: rd_data after edge N reflects rd_ch/rd_addr and state sampled at edge N. A write at edge N is visible via a read sampled at edge N+1.
- prescale=0, src=0, reload=R, enable written at edge E0: count decrements at E1..ER, and at E(R+1) it reloads R with tc_pulse high for exactly one cycle. tc then repeats every R+1 cycles.
- prescale=P: each decrement takes P+1 cycles. The first tick occurs at edge E0+P+1 after enable.
- ext source: the rising edge of ext_tick sampled at edge N is acted on at edge N. A level held high produces only one tick.
- flag sets on the same edge tc_pulse rises. irq rises on that edge if irq_en=1.

## Test plan
- Periodic, P=0: reload=3, control=0b1001 → tc_pulse ch0 every 4 cycles, count sequence 3,2,1,0,3; irq0=1 after the first tc; flag-clear write drops irq0 next cycle.
- Prescaled one-shot: prescale=4, reload=2, control=0b0011 → a single tc 15 cycles after enable; enable reads back 0; count stays 0 with no further pulses.
- External source on ch1: control=0b0101, reload=1; ext_tick held high for 5 cycles, then 3 separate 1-cycle pulses → exactly 4 ticks total, and tc on the 2nd and 4th ticks.
- Collisions: reload write coincident with the count==0 tick → no tc_pulse, count=new value. Flag-clear coincident with tc → flag remains 1.
- Independence and reads: run all channels with different reload values; check each tc spacing. Read every rd_addr with 1-cycle latency. rd_ch=3 (CHANNELS=3) returns 0.
- Reset mid-count (count=5, flag=1, pre_cnt≠0), asynchronously between edges → all outputs 0 immediately; after reset no ticks occur until reconfigured.
